// File: rtl/csi_sync_fifo_pkg.sv
// Shared CSI FIFO sizing constants and payload type.
// The DATA_W default of csi_sync_fifo is derived from t_fifo_data.
package csi_param_pkg;
  localparam int CSI_FIFO_MAX_SIZE  = 16;
  localparam int CSI_FIFO_AF_MARGIN = 2;
  localparam int CSI_FIFO_AE_LEVEL  = 2;
endpackage

package csi_typedef_pkg;
  typedef logic [7:0] t_fifo_data;
endpackage

// File: rtl/csi_fifo_ram.sv
// DEPTH x DATA_W storage: clocked write port, asynchronous read port.
// Kept standalone so a vendor RAM macro can be dropped in later.
module csi_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     Clk,
  input  logic                     WrEn,
  input  logic [$clog2(DEPTH)-1:0] WrAddr,
  input  logic [DATA_W-1:0]        WrData,
  input  logic [$clog2(DEPTH)-1:0] RdAddr,
  output logic [DATA_W-1:0]        RdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (WrEn) begin
      mem[WrAddr] <= WrData;
    end
  end

  // Combinational read gives the top its first-word-fall-through head.
  assign RdData = mem[RdAddr];

endmodule

// File: rtl/csi_sync_fifo.sv
// Single-clock FWFT FIFO between CI capture (Rx) and CSI packetiser (Tx),
// with registered occupancy flags, synchronous flush and sticky overflow.
module csi_sync_fifo
  import csi_param_pkg::*;
  import csi_typedef_pkg::*;
#(
  parameter int DATA_W   = $bits(t_fifo_data),
  parameter int DEPTH    = CSI_FIFO_MAX_SIZE,
  parameter int AF_LEVEL = DEPTH - CSI_FIFO_AF_MARGIN,
  parameter int AE_LEVEL = CSI_FIFO_AE_LEVEL
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Flush,
  input  logic                       ValidRx,
  input  logic [DATA_W-1:0]          DataRx,
  output logic                       FullRx,
  output logic                       AlmostFullRx,
  input  logic                       ReadyTx,
  output logic [DATA_W-1:0]          DataTx,
  output logic                       EmptyTx,
  output logic                       AlmostEmptyTx,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       OverflowErr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gDepthCheck
    $fatal(1, "csi_sync_fifo: DEPTH must be a power of 2 and >= 4");
  end
  if (!((AE_LEVEL > 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL < DEPTH))) begin : gLevelCheck
    $fatal(1, "csi_sync_fifo: need 0 < AE_LEVEL < AF_LEVEL < DEPTH");
  end

  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] countNext;
  logic          wrEn;
  logic          rdEn;

  // Acceptance uses the registered flags, so a write against a full FIFO is
  // refused even if a read frees a slot in the same cycle.
  always_comb begin
    wrEn      = ValidRx & ~FullRx & ~Flush;
    rdEn      = ReadyTx & ~EmptyTx & ~Flush;
    countNext = Count;
    if (Flush) begin
      countNext = '0;
    end else if (wrEn && !rdEn) begin
      countNext = Count + CW'(1'b1);
    end else if (rdEn && !wrEn) begin
      countNext = Count - CW'(1'b1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wrPtr         <= '0;
      rdPtr         <= '0;
      Count         <= '0;
      FullRx        <= 1'b0;
      EmptyTx       <= 1'b1;
      AlmostFullRx  <= 1'b0;
      AlmostEmptyTx <= 1'b1;
      OverflowErr   <= 1'b0;
    end else begin
      if (Flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (wrEn) wrPtr <= wrPtr + PW'(1'b1);
        if (rdEn) rdPtr <= rdPtr + PW'(1'b1);
      end
      Count         <= countNext;
      FullRx        <= (countNext == DEPTH_C);
      EmptyTx       <= (countNext == '0);
      AlmostFullRx  <= (countNext >= AF_C);
      AlmostEmptyTx <= (countNext <= AE_C);
      OverflowErr   <= Flush ? 1'b0 : (OverflowErr | (ValidRx & FullRx));
    end
  end

  csi_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) uRam (
    .Clk    (Clk),
    .WrEn   (wrEn),
    .WrAddr (wrPtr),
    .WrData (DataRx),
    .RdAddr (rdPtr),
    .RdData (DataTx)
  );

endmodule
